// File: rtl/decode_extend_stage.sv
// Decode/immediate-extend pipeline stage.
// Decodes the RISC-V immediate ahead of a one-deep output register backed by a
// single skid register, so held beats already carry their extended immediate.
module decode_extend_stage #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned INST_SIZE = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [INST_SIZE-1:0]        i_instr,
    input  logic [DATA_SIZE-1:0]        i_pc,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [INST_SIZE-1:0]        o_instr,
    output logic [DATA_SIZE-1:0]        o_pc,
    output logic signed [DATA_SIZE-1:0] o_immediate,
    output logic [2:0]                  o_imm_fmt,
    output logic [DATA_SIZE-1:0]        o_target
);

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpAlcI   = 7'b0010011,
        OpAuipc  = 7'b0010111,
        OpStore  = 7'b0100011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJalr   = 7'b1100111,
        OpJal    = 7'b1101111,
        OpSystem = 7'b1110011
    } t_opcode;

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
    localparam logic [2:0] FmtZ    = 3'd6;

    t_opcode                opcode;
    logic signed [31:0]     imm32;
    logic [2:0]             dec_fmt;
    logic [DATA_SIZE-1:0]   dec_imm;

    logic                   out_valid_q, out_valid_d;
    logic [INST_SIZE-1:0]   out_instr_q, out_instr_d;
    logic [DATA_SIZE-1:0]   out_pc_q,    out_pc_d;
    logic [DATA_SIZE-1:0]   out_imm_q,   out_imm_d;
    logic [2:0]             out_fmt_q,   out_fmt_d;

    logic                   skid_valid_q, skid_valid_d;
    logic [INST_SIZE-1:0]   skid_instr_q, skid_instr_d;
    logic [DATA_SIZE-1:0]   skid_pc_q,    skid_pc_d;
    logic [DATA_SIZE-1:0]   skid_imm_q,   skid_imm_d;
    logic [2:0]             skid_fmt_q,   skid_fmt_d;

    logic                   in_accept;

    // Immediate decode; Z format is built positive so sign extension zero-fills it.
    always_comb begin
        opcode  = t_opcode'(i_instr[6:0]);
        imm32   = '0;
        dec_fmt = FmtNone;
        case (opcode)
            OpLoad, OpAlcI, OpJalr: begin
                imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                dec_fmt = FmtI;
            end
            OpStore: begin
                imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                dec_fmt = FmtS;
            end
            OpBranch: begin
                imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
                dec_fmt = FmtB;
            end
            OpLui, OpAuipc: begin
                imm32   = {i_instr[31:12], 12'h000};
                dec_fmt = FmtU;
            end
            OpJal: begin
                imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
                dec_fmt = FmtJ;
            end
            OpSystem: begin
                if (i_instr[14]) begin
                    imm32   = {27'd0, i_instr[19:15]};
                    dec_fmt = FmtZ;
                end else begin
                    imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                    dec_fmt = FmtI;
                end
            end
            default: begin
                imm32   = '0;
                dec_fmt = FmtNone;
            end
        endcase
        dec_imm = DATA_SIZE'(imm32);
    end

    assign in_accept = i_valid && o_ready;

    // Output/skid next state; flush drops every held or incoming beat.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_valid_q && !i_ready) begin
            // Output stalled: a new beat can only land in the (empty) skid.
            if (in_accept) begin
                skid_valid_d = 1'b1;
                skid_instr_d = i_instr;
                skid_pc_d    = i_pc;
                skid_imm_d   = dec_imm;
                skid_fmt_d   = dec_fmt;
            end
        end else if (skid_valid_q) begin
            // Output empty or draining: older skid beat goes first.
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_pc_d     = skid_pc_q;
            out_imm_d    = skid_imm_q;
            out_fmt_d    = skid_fmt_q;
            skid_valid_d = 1'b0;
        end else if (in_accept) begin
            out_valid_d = 1'b1;
            out_instr_d = i_instr;
            out_pc_d    = i_pc;
            out_imm_d   = dec_imm;
            out_fmt_d   = dec_fmt;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            out_fmt_q    <= FmtNone;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FmtNone;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
        end
    end

    // Outputs come straight from flops; target is the only combinational result.
    always_comb begin
        o_ready     = ~skid_valid_q;
        o_valid     = out_valid_q;
        o_instr     = out_instr_q;
        o_pc        = out_pc_q;
        o_immediate = out_imm_q;
        o_imm_fmt   = out_fmt_q;
        o_target    = out_pc_q + out_imm_q;
    end

endmodule
